// File: rtl/lane_count_arbiter.sv
// ---------------------------------------------------------------------------
// lane_count_arbiter
//
// Multi-lane front end for the vehicle counter. Each lane's detector line is
// asynchronous to the clock. The block synchronizes it and turns each rising
// edge into a queued event in a small per-lane pending counter. Queued events
// are then granted round-robin, at most one per clock, onto a single shared
// decimal total that runs 0..MAX_COUNT and wraps to 0.
//
// Ports:
//   i_clk         system clock, all state on the rising edge
//   i_rst_n       asynchronous active-low reset, clears all state and outputs
//   i_detector    raw sensor lines, one bit per lane, asynchronous to i_clk
//   i_enable      high allows grants; low still queues edges but grants nothing
//   i_clear       synchronous clear of count, queues, flags and pointer
//   o_count       running total, 0..MAX_COUNT
//   o_inc_pulse   one-cycle pulse per granted increment
//   o_grant_lane  lane index of the most recent grant; holds between grants
//   o_wrap        one-cycle pulse when the total goes MAX_COUNT -> 0
//   o_drop        sticky per-lane flag: an edge was lost to queue saturation
//   o_busy        registered "some lane has a queued event"
// ---------------------------------------------------------------------------
module lane_count_arbiter #(
    parameter int LANES     = 4,
    parameter int PEND_W    = 3,
    parameter int MAX_COUNT = 9999
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [LANES-1:0] i_detector,
    input  logic             i_enable,
    input  logic             i_clear,
    output logic [13:0]      o_count,
    output logic             o_inc_pulse,
    output logic [2:0]       o_grant_lane,
    output logic             o_wrap,
    output logic [LANES-1:0] o_drop,
    output logic             o_busy
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [13:0]       MAX_C    = 14'(MAX_COUNT);
    localparam logic [3:0]        LANES_4  = 4'(LANES);

    logic [LANES-1:0]  r_s1;
    logic [LANES-1:0]  r_s2;
    logic [LANES-1:0]  r_p;
    logic [PEND_W-1:0] r_pend [LANES];
    logic [LANES-1:0]  r_drop;
    logic [2:0]        r_ptr;
    logic [13:0]       r_count;
    logic              r_inc;
    logic [2:0]        r_grantLane;
    logic              r_wrap;
    logic              r_busy;

    logic [LANES-1:0]  w_edge;
    logic [LANES-1:0]  w_nz;
    logic [7:0]        w_nzPad;
    logic [3:0]        w_cand;
    logic              w_found;
    logic [2:0]        w_grantIdx;
    logic              w_grant;
    logic [LANES-1:0]  w_dec;
    logic [3:0]        w_ptrSum;
    logic [2:0]        w_ptrNext;

    // Two-flop synchronizer plus a previous-value flop per lane. These keep
    // running through clear so a detector held high across a clear does not
    // produce a fresh edge afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_p  <= '0;
        end else begin
            r_s1 <= i_detector;
            r_s2 <= r_s1;
            r_p  <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_p;

    // Lanes with something queued, padded to 8 bits so a 3-bit lane index
    // can address it regardless of LANES.
    always_comb begin
        w_nzPad = '0;
        for (int i = 0; i < LANES; i++) begin
            w_nz[i] = (r_pend[i] != '0);
        end
        w_nzPad[LANES-1:0] = w_nz;
    end

    // Round-robin search: first non-empty lane at or after the pointer,
    // wrapping modulo LANES.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        w_cand     = '0;
        for (int k = 0; k < LANES; k++) begin
            w_cand = {1'b0, r_ptr} + 4'(k);
            if (w_cand >= LANES_4) begin
                w_cand = w_cand - LANES_4;
            end
            if (!w_found && w_nzPad[w_cand[2:0]]) begin
                w_found    = 1'b1;
                w_grantIdx = w_cand[2:0];
            end
        end
    end

    assign w_grant   = i_enable & ~i_clear & w_found;
    assign w_ptrSum  = {1'b0, w_grantIdx} + 4'd1;
    assign w_ptrNext = (w_ptrSum >= LANES_4) ? 3'd0 : w_ptrSum[2:0];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_dec[i] = w_grant && (w_grantIdx == 3'(i));
        end
    end

    // Pending queues and drop flags. An edge and a grant on the same lane in
    // the same cycle cancel, so a full queue being drained never drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_pend[i] <= '0;
            end
            r_drop <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < LANES; i++) begin
                r_pend[i] <= '0;
            end
            r_drop <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (w_edge[i] && !w_dec[i]) begin
                    if (r_pend[i] == PEND_MAX) begin
                        r_drop[i] <= 1'b1;
                    end else begin
                        r_pend[i] <= r_pend[i] + 1'b1;
                    end
                end else if (!w_edge[i] && w_dec[i]) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
            end
        end
    end

    // Shared total, grant reporting, pointer and busy. Busy is sampled from
    // the current queues, so it trails the pending counters by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_inc       <= 1'b0;
            r_grantLane <= '0;
            r_wrap      <= 1'b0;
            r_ptr       <= '0;
            r_busy      <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_inc   <= 1'b0;
            r_wrap  <= 1'b0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_inc  <= w_grant;
            r_wrap <= 1'b0;
            r_busy <= |w_nz;
            if (w_grant) begin
                r_grantLane <= w_grantIdx;
                r_ptr       <= w_ptrNext;
                if (r_count == MAX_C) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + 14'd1;
                end
            end
        end
    end

    assign o_count      = r_count;
    assign o_inc_pulse  = r_inc;
    assign o_grant_lane = r_grantLane;
    assign o_wrap       = r_wrap;
    assign o_drop       = r_drop;
    assign o_busy       = r_busy;

endmodule

// File: doc/lane_count_arbiter.md
# lane_count_arbiter

Multi-lane front end for the vehicle counter. It synchronizes up to LANES asynchronous vehicle-detector inputs and queues their rising edges per lane. It arbitrates the queued events round-robin onto a single shared 4-digit total counter, at most one increment per clock. It sits between the lane sensors and the display/BCD path, replacing per-lane direct drive of the count register.

## Interface
- LANES, 4, number of detector lanes (2..8)
- PEND_W, 3, width of each lane's pending-event counter (saturates at 2^PEND_W-1)
- MAX_COUNT, 9999, last value of the total before wrap to 0
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; all state and outputs cleared while low
- detector  in  LANES  raw sensor lines, asynchronous to clk, one bit per lane
- enable  in  1  high: grants allowed; low: edges still queued, no grants
- clear  in  1  synchronous clear of count, queues, flags and pointer (while reset high)
- count  out  14  running total, 0..MAX_COUNT
- inc_pulse  out  1  high for exactly one cycle per granted increment
- grant_lane  out  3  lane index of the last grant; valid when inc_pulse is high, holds otherwise
- wrap  out  1  one-cycle pulse when count goes MAX_COUNT -> 0
- drop  out  LANES  sticky per-lane flag: an edge was lost to pending saturation
- busy  out  1  high when any lane's pending counter is non-zero

## Operation
- Reset: count=0, inc_pulse=0, grant_lane=0, wrap=0, drop=0, busy=0, all pending=0, synchronizer and edge registers=0, RR pointer=0.
- Synchronizer per lane: two flops (s1, s2) plus a previous-value flop p. edge[i] = s2 & ~p.
- Pending update per lane, per cycle. Edge only: pending+1. Grant only: pending-1. Both: unchanged. Neither: unchanged.
- Edge with pending at max and no grant on that lane: pending stays at max, drop[i] set.
- Edge at max with a same-cycle grant on that lane: net unchanged, drop not set.
- Arbiter: combinational over current pending registers. Among lanes with pending != 0, pick the first at or after the RR pointer, searching upward modulo LANES.
  - On a grant to lane g, the pointer becomes (g+1) mod LANES.
  - No grant when enable=0, clear=1, or all pending are 0. The pointer holds when there is no grant.
- Grant effects, registered at the same edge:
  - pending[g] decrements.
  - count = (count==MAX_COUNT) ? 0 : count+1.
  - wrap=1 only on the 0 transition.
  - inc_pulse=1.
  - grant_lane=g.
- Non-grant cycle: inc_pulse=0, wrap=0; count and grant_lane hold.
- clear=1, applied at the next edge:
  - count, pending, drop and RR pointer go to 0.
  - inc_pulse=0, wrap=0.
  - Edges detected in the clear cycle are discarded.
  - Synchronizer flops keep running, so a held-high detector does not re-trigger after clear.
- busy: registered OR of (pending != 0).
- Reset asserted mid-operation: immediate clear of everything. Queued events are lost. No inc_pulse on release.

## Timing
- Detector high and low times must each be at least 2 clk periods to be counted exactly once.
- Latency: let E0 be the edge at which s1 first captures 1. Then pending increments at E2. The earliest grant (count update, inc_pulse) is at E3. busy rises at E3.
- Throughput: at most 1 increment per cycle across all lanes. N simultaneous single edges on idle lanes drain in N consecutive cycles.
- Fairness: a lane with pending != 0 is granted within LANES cycles while enable=1.
- enable falling: no grant at that edge. enable rising: a grant is possible at the next edge.

## Test plan
- **Reset:** reset low with detector toggling -> all outputs 0; release and idle 10 cycles -> count=0, busy=0.
- **Single lane:** one 4-cycle pulse on lane 2 -> exactly one inc_pulse at E3, grant_lane=2, count 0->1; busy high for 1 cycle.
- **Simultaneous lanes:** lanes 0-3 rise on the same cycle, pointer=1 -> grants in order 1,2,3,0 on four consecutive cycles; count=4; pointer ends at 1.
- **Saturation:** enable=0, 9 clean pulses on lane 0 (PEND_W=3) -> pending=7, drop[0]=1. Then enable=1 -> 7 consecutive inc_pulses, count=7, drop[0] stays 1.
- **Wrap:** preload via 9999 events -> count=9999. One more event -> count=0, wrap=1 for one cycle with inc_pulse=1.
- **Clear and reset mid-drain:** 3 events queued on lane 1, clear asserted during the first grant cycle -> next edge count=0, pending=0, drop=0, no further inc_pulse. Repeat with reset low instead -> same result, applied asynchronously.
